// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin memory bus arbiter.
// Holds the state encoding, the watchdog error word and the index width helper.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam logic [31:0] BUS_ERR_WORD = 32'hDEADBEEF;

  // Index width for n items; never below one bit so single-master builds still have a port
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N. Stands alone so it can be exercised in isolation.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt,
  output logic         any
);

  int j;

  // Scan from the farthest candidate back to ptr so the nearest request wins
  always_comb begin
    gnt = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end else begin
        j = j;
      end
      if (req[j]) begin
        gnt = W'(j);
      end else begin
        gnt = gnt;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter putting several PicoRV32-style masters onto the shared SoC
// memory bus, with a watchdog that completes hung transfers with an error word.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int MASTER_CNT  = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                    clk48m,
  input  logic                    resetn,
  input  logic [32*MASTER_CNT-1:0] addr,
  input  logic [32*MASTER_CNT-1:0] wdata,
  input  logic [4*MASTER_CNT-1:0]  wen,
  input  logic [MASTER_CNT-1:0]    valid,
  output logic [MASTER_CNT-1:0]    ready,
  output logic [32*MASTER_CNT-1:0] rdata,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wen,
  output logic                     s_valid,
  input  logic                     s_ready,
  input  logic [31:0]              s_rdata,
  output logic [31:0]              currmaster,
  output logic                     bus_timeout
);

  localparam int IW = idx_width(MASTER_CNT);
  localparam int CW = idx_width(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(MASTER_CNT - 1);
  localparam logic [CW-1:0] WD_TERM  = CW'(TIMEOUT_CYC - 1);

  arb_state_t    state;
  logic [IW-1:0] grant;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick;
  logic [IW-1:0] next_ptr;
  logic [CW-1:0] wd_cnt;
  logic          pick_any;
  logic          busy;
  logic          gvalid;
  logic          wd_hit;
  logic          done;

  rr_pick #(
    .N(MASTER_CNT),
    .W(IW)
  ) u_pick (
    .req(valid),
    .ptr(rr_ptr),
    .gnt(pick),
    .any(pick_any)
  );

  // Transfer termination: slave completion beats the watchdog, which beats nothing
  always_comb begin
    busy     = (state == BUSY);
    gvalid   = valid[grant];
    wd_hit   = busy && gvalid && !s_ready && (wd_cnt == WD_TERM);
    done     = busy && (s_ready || wd_hit || !gvalid);
    next_ptr = (grant == LAST_IDX) ? '0 : grant + 1'b1;
  end

  // Slave-side mux and master-side completion, steered by the registered grant
  always_comb begin
    s_addr      = addr[32*int'(grant) +: 32];
    s_wdata     = wdata[32*int'(grant) +: 32];
    s_wen       = 4'b0000;
    s_valid     = 1'b0;
    ready       = '0;
    if (busy) begin
      s_wen        = wen[4*int'(grant) +: 4];
      s_valid      = gvalid && !wd_hit;
      ready[grant] = s_ready || wd_hit;
    end else begin
      s_wen   = 4'b0000;
      s_valid = 1'b0;
      ready   = '0;
    end
    rdata       = {MASTER_CNT{wd_hit ? BUS_ERR_WORD : s_rdata}};
    bus_timeout = wd_hit;
  end

  // Arbitration FSM, grant/pointer registers and watchdog counter
  always_ff @(posedge clk48m) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      currmaster <= 32'd0;
      wd_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant      <= pick;
            currmaster <= 32'(pick);
            wd_cnt     <= '0;
            state      <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (done) begin
            rr_ptr <= next_ptr;
            state  <= RELEASE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        // One dead cycle so the served master can drop valid before re-arbitration
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr (2 masters, 8-cycle watchdog) using a
// queue of expected completions popped whenever a ready pulse appears.
module tb_bus_arbiter_rr;

  logic        clk48m = 1'b0;
  logic        resetn = 1'b0;
  logic [63:0] addr   = 64'd0;
  logic [63:0] wdata  = 64'd0;
  logic [7:0]  wen    = 8'd0;
  logic [1:0]  valid  = 2'd0;
  logic [1:0]  ready;
  logic [63:0] rdata;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wen;
  logic        s_valid;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = 32'd0;
  logic [31:0] currmaster;
  logic        bus_timeout;

  bus_arbiter_rr #(
    .MASTER_CNT(2),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk48m(clk48m),
    .resetn(resetn),
    .addr(addr),
    .wdata(wdata),
    .wen(wen),
    .valid(valid),
    .ready(ready),
    .rdata(rdata),
    .s_addr(s_addr),
    .s_wdata(s_wdata),
    .s_wen(s_wen),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_rdata(s_rdata),
    .currmaster(currmaster),
    .bus_timeout(bus_timeout)
  );

  always #5 clk48m = ~clk48m;

  typedef struct {
    int          m;
    logic [31:0] data;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk48m);
    @(negedge clk48m);
  endtask

  task automatic push(input int m, input logic [31:0] d, input logic to);
    exp_t e;
    e.m = m; e.data = d; e.to = to;
    sb.push_back(e);
  endtask

  task automatic expect_done(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_ready"}, 32'(ready), 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_ready"}, 32'(ready), 32'd1 << e.m);
      for (int i = 0; i < 2; i++) chk({tag, "_rdata"}, rdata[32*i +: 32], e.data);
      chk({tag, "_bus_timeout"}, 32'(bus_timeout), 32'(e.to));
    end
  endtask

  task automatic wait_svalid(input int budget);
    int w;
    w = 0;
    step();
    while (!s_valid && w < budget) begin
      step();
      w++;
    end
    chk("svalid_wait", 32'(s_valid), 32'd1);
  endtask

  task automatic xfer(input int m, input int lat, input logic [31:0] data,
                      input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] ewen);
    push(m, data, 1'b0);
    wait_svalid(10);
    chk("s_addr", s_addr, ea);
    chk("s_wdata", s_wdata, ew);
    chk("s_wen", 32'(s_wen), 32'(ewen));
    repeat (lat) begin
      chk("ready_early", 32'(ready), 32'd0);
      step();
    end
    s_ready = 1'b1;
    s_rdata = data;
    #1;
    expect_done("xfer");
    step();
    chk("release_svalid", 32'(s_valid), 32'd0);
    chk("release_ready", 32'(ready), 32'd0);
    s_ready = 1'b0;
  endtask

  initial begin
    int exp_m[4];
    int seen;
    int last;
    int first;

    // Reset values
    repeat (2) step();
    chk("rst_svalid", 32'(s_valid), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_currmaster", currmaster, 32'd0);
    chk("rst_timeout", 32'(bus_timeout), 32'd0);
    chk("rst_swen", 32'(s_wen), 32'd0);
    resetn = 1'b1;

    // Single read from master 0, slave answers two cycles after s_valid
    addr[31:0] = 32'h4000_0000;
    valid      = 2'b01;
    xfer(0, 2, 32'h1234_5678, 32'h4000_0000, 32'h0, 4'h0);
    chk("t1_currmaster", currmaster, 32'd0);
    valid = 2'b00;
    step();
    chk("t1_idle_svalid", 32'(s_valid), 32'd0);
    step();
    chk("t1_idle2_svalid", 32'(s_valid), 32'd0);

    // Both masters requesting back to back with a single-cycle slave
    resetn = 1'b0;
    step();
    chk("t2_rst_svalid", 32'(s_valid), 32'd0);
    resetn  = 1'b1;
    addr    = {32'h1000_0004, 32'h1000_0000};
    valid   = 2'b11;
    s_ready = 1'b1;
    s_rdata = 32'h600D_F00D;
    exp_m   = '{0, 1, 0, 1};
    for (int k = 0; k < 4; k++) push(exp_m[k], 32'h600D_F00D, 1'b0);
    seen = 0; last = 0; first = 0;
    for (int i = 1; i <= 16 && seen < 4; i++) begin
      step();
      if (ready != 2'b00) begin
        chk("rr_currmaster", currmaster, 32'(exp_m[seen]));
        chk("rr_addr", s_addr, 32'h1000_0000 + 32'(4 * exp_m[seen]));
        if (seen > 0) chk("rr_period", 32'(i - last), 32'd3);
        else first = i;
        last = i;
        expect_done("rr");
        seen++;
      end
    end
    chk("rr_count", 32'(seen), 32'd4);
    chk("rr_first_latency", 32'(first), 32'd1);
    valid   = 2'b00;
    s_ready = 1'b0;
    step();
    step();

    // Master 1 byte write
    addr[63:32]  = 32'h2000_0000;
    wdata[63:32] = 32'h0000_003F;
    wen[7:4]     = 4'b0001;
    valid        = 2'b10;
    xfer(1, 1, 32'h0, 32'h2000_0000, 32'h0000_003F, 4'b0001);
    valid = 2'b00;
    wen   = 8'd0;
    wdata = 64'd0;
    step();

    // Watchdog expiry on master 0, then master 1 gets the bus
    addr  = {32'h3000_0004, 32'h3000_0000};
    valid = 2'b11;
    push(0, 32'hDEAD_BEEF, 1'b1);
    wait_svalid(10);
    chk("wd_currmaster", currmaster, 32'd0);
    for (int k = 1; k <= 7; k++) begin
      chk("wd_quiet_ready", 32'(ready), 32'd0);
      chk("wd_quiet_timeout", 32'(bus_timeout), 32'd0);
      step();
    end
    expect_done("wd");
    chk("wd_svalid_forced", 32'(s_valid), 32'd0);
    step();
    chk("wd_rel_timeout", 32'(bus_timeout), 32'd0);
    chk("wd_rel_ready", 32'(ready), 32'd0);
    wait_svalid(10);
    chk("wd_next_currmaster", currmaster, 32'd1);
    chk("wd_next_addr", s_addr, 32'h3000_0004);
    push(1, 32'h1111_2222, 1'b0);
    s_ready = 1'b1;
    s_rdata = 32'h1111_2222;
    #1;
    expect_done("wd_next");
    step();
    s_ready = 1'b0;
    valid   = 2'b00;
    step();

    // Slave completion on the watchdog terminal cycle
    valid = 2'b01;
    push(0, 32'hCAFE_0005, 1'b0);
    wait_svalid(10);
    repeat (7) step();
    chk("tc_at_terminal", 32'(bus_timeout), 32'd1);
    s_ready = 1'b1;
    s_rdata = 32'hCAFE_0005;
    #1;
    expect_done("tc");
    step();
    s_ready = 1'b0;
    valid   = 2'b00;
    step();

    // Reset in the middle of a transfer to master 1
    valid = 2'b11;
    wait_svalid(10);
    chk("mid_currmaster", currmaster, 32'd1);
    resetn = 1'b0;
    step();
    chk("mid_rst_svalid", 32'(s_valid), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_currmaster", currmaster, 32'd0);
    resetn = 1'b1;
    wait_svalid(10);
    chk("post_rst_currmaster", currmaster, 32'd0);
    chk("post_rst_addr", s_addr, 32'h3000_0000);

    // Master 0 abandons its request: no ready, pointer still advances
    valid = 2'b10;
    #1;
    chk("abort_ready", 32'(ready), 32'd0);
    step();
    chk("abort_rel_svalid", 32'(s_valid), 32'd0);
    chk("abort_rel_ready", 32'(ready), 32'd0);
    wait_svalid(10);
    chk("abort_next_currmaster", currmaster, 32'd1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
